// File: rtl/qspi_arb_pkg.sv
// ============================================================================
// Module      : qspi_arb_pkg
// Description : Shared definitions for the QSPI read arbiter: FSM state
//               encoding and requester index constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package qspi_arb_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 3'd0;
    localparam arb_state_t ST_LAUNCH = 3'd1;
    localparam arb_state_t ST_RUN_I  = 3'd2;
    localparam arb_state_t ST_RUN_D  = 3'd3;
    localparam arb_state_t ST_HALT   = 3'd4;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/qspi_arb_addr_track.sv
// ============================================================================
// Module      : qspi_arb_addr_track
// Description : Next-address register for one requester stream. Loaded with
//               the start address at launch, advanced by one data beat per
//               consumed beat, wrapping modulo 2^ADDR_BITS.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               load/load_addr - load the stream start address
//               beat           - one beat consumed this cycle
//               next_addr      - address of the next unread byte
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module qspi_arb_addr_track
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_BITS        = 24,
    parameter int DATA_WIDTH_BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic                 beat,
    output logic [ADDR_BITS-1:0] next_addr
);

    localparam logic [ADDR_BITS-1:0] c_step = ADDR_BITS'(DATA_WIDTH_BYTES);

    logic [ADDR_BITS-1:0] r_next;

    // Addition at ADDR_BITS width gives the modulo wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next <= '0;
        end else if (load) begin
            r_next <= load_addr;
        end else if (beat) begin
            r_next <= r_next + c_step;
        end
    end

    assign next_addr = r_next;

endmodule

`default_nettype wire

// File: rtl/qspi_read_arbiter.sv
// ============================================================================
// Module      : qspi_read_arbiter
// Description : Shares one read-only QSPI flash controller between an
//               instruction-fetch requester (I) and a data-load requester (D).
//               D has priority and pre-empts a running I stream. Each stream's
//               next address is tracked; ctl_addr shows the current owner's.
// Ports       : i_* / d_*  - requester handshakes (addr, start, stall, stop,
//                            ready) plus i_abort pre-emption pulse
//               ctl_*      - controller strobes, address, data and status
//               data_out   - controller data passed through
// Config      : QSPI_ARB_RESUME_EN - when defined, a pre-empted I stream is
//               relaunched automatically at its saved next address instead
//               of being aborted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module qspi_read_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int ADDR_BITS        = 24,
    parameter int DATA_WIDTH_BYTES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_BITS-1:0]          i_addr,
    input  logic                          i_start,
    input  logic                          i_stall,
    input  logic                          i_stop,
    output logic                          i_ready,
    output logic                          i_abort,
    input  logic [ADDR_BITS-1:0]          d_addr,
    input  logic                          d_start,
    input  logic                          d_stall,
    input  logic                          d_stop,
    output logic                          d_ready,
    output logic [DATA_WIDTH_BYTES*8-1:0] data_out,
    output logic [ADDR_BITS-1:0]          ctl_addr,
    output logic                          ctl_start,
    output logic                          ctl_stall,
    output logic                          ctl_stop,
    input  logic [DATA_WIDTH_BYTES*8-1:0] ctl_data,
    input  logic                          ctl_ready,
    input  logic                          ctl_busy
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_owner;
    logic                 r_pend_i;
    logic                 r_pend_d;
    logic [ADDR_BITS-1:0] r_pend_addr_i;
    logic [ADDR_BITS-1:0] r_pend_addr_d;
    logic                 r_halt_first;   // first HALT cycle: stop strobe
    logic                 r_preempt;      // current HALT caused by D pre-empting I

    logic                 w_run_i;
    logic                 w_run_d;
    logic                 w_beat_i;
    logic                 w_beat_d;
    logic                 w_d_want;
    logic                 w_preempt;
    logic                 w_can_exit;
    logic                 w_arb_ok;
    logic                 w_launch_i;
    logic                 w_launch_d;
    logic                 w_launch;
    logic [ADDR_BITS-1:0] w_next_i;
    logic [ADDR_BITS-1:0] w_next_d;

    assign w_run_i  = (r_state == ST_RUN_I);
    assign w_run_d  = (r_state == ST_RUN_D);
    assign w_beat_i = w_run_i & ctl_ready & ~i_stall;
    assign w_beat_d = w_run_d & ctl_ready & ~d_stall;

    // D wants the controller if it asks now or is still waiting (and not
    // withdrawing the request this cycle).
    assign w_d_want  = d_start | (r_pend_d & ~d_stop);
    // A stop or restart from I ends the stream on its own terms; only a
    // plain D request while I runs counts as pre-emption.
    assign w_preempt = w_run_i & ~i_stop & ~i_start & w_d_want;

    // Leaving HALT waits one cycle past the stop strobe and for the
    // controller to report idle.
    assign w_can_exit = (r_state == ST_HALT) & ~r_halt_first & ~ctl_busy;
    assign w_arb_ok   = (r_state == ST_IDLE) | w_can_exit;
    assign w_launch_d = w_arb_ok & r_pend_d;
    assign w_launch_i = w_arb_ok & ~r_pend_d & r_pend_i;
    assign w_launch   = w_launch_d | w_launch_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = (r_owner == REQ_D) ? ST_RUN_D : ST_RUN_I;
            end
            ST_RUN_I: begin
                if (i_stop || i_start || w_d_want) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_RUN_D: begin
                if (d_stop || d_start) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (w_can_exit) begin
                    w_state_nxt = w_launch ? ST_LAUNCH : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= REQ_I;
            r_halt_first <= 1'b0;
            r_preempt    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_first <= (w_state_nxt == ST_HALT) && (r_state != ST_HALT);
            if (w_launch) begin
                r_owner <= w_launch_d ? REQ_D : REQ_I;
            end
            // Cause is captured on HALT entry and held for the whole HALT.
            if (r_state != ST_HALT) begin
                r_preempt <= w_preempt;
            end
        end
    end

    // A new start always wins (it overwrites the address even if the bit is
    // being cleared by a launch in the same cycle).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_d      <= 1'b0;
            r_pend_addr_d <= '0;
        end else if (d_start) begin
            r_pend_d      <= 1'b1;
            r_pend_addr_d <= d_addr;
        end else if (w_launch_d || d_stop) begin
            r_pend_d      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_i      <= 1'b0;
            r_pend_addr_i <= '0;
        end else if (i_start) begin
            r_pend_i      <= 1'b1;
            r_pend_addr_i <= i_addr;
        end else if (w_launch_i || i_stop) begin
            r_pend_i      <= 1'b0;
`ifdef QSPI_ARB_RESUME_EN
        end else if (r_halt_first && r_preempt && !r_pend_i) begin
            // Tracker already includes any beat taken in the pre-empt cycle.
            r_pend_i      <= 1'b1;
            r_pend_addr_i <= w_next_i;
`endif
        end
    end

    qspi_arb_addr_track #(
        .ADDR_BITS        (ADDR_BITS),
        .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES)
    ) u_track_i (
        .clk       (clk),
        .rst       (rst),
        .load      (w_launch_i),
        .load_addr (r_pend_addr_i),
        .beat      (w_beat_i),
        .next_addr (w_next_i)
    );

    qspi_arb_addr_track #(
        .ADDR_BITS        (ADDR_BITS),
        .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES)
    ) u_track_d (
        .clk       (clk),
        .rst       (rst),
        .load      (w_launch_d),
        .load_addr (r_pend_addr_d),
        .beat      (w_beat_d),
        .next_addr (w_next_d)
    );

    always_comb begin
        ctl_stall = 1'b0;
        if (w_run_i) begin
            ctl_stall = i_stall;
        end else if (w_run_d) begin
            ctl_stall = d_stall;
        end
    end

    assign ctl_start = (r_state == ST_LAUNCH);
    assign ctl_stop  = r_halt_first;
    assign ctl_addr  = (r_owner == REQ_D) ? w_next_d : w_next_i;
    assign i_ready   = w_run_i & ctl_ready;
    assign d_ready   = w_run_d & ctl_ready;
    assign data_out  = ctl_data;

`ifdef QSPI_ARB_RESUME_EN
    assign i_abort = 1'b0;
`else
    assign i_abort = r_halt_first & r_preempt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qspi_read_arbiter.sv
// ============================================================================
// Module      : tb_qspi_read_arbiter
// Description : Self-checking bench for qspi_read_arbiter: a vector table for
//               a plain I stream and a simultaneous I/D request, then directed
//               sequences for pre-emption, stall, wrap and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_qspi_read_arbiter;

`ifdef QSPI_ARB_RESUME_EN
    localparam bit RESUME = 1'b1;
`else
    localparam bit RESUME = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] i_addr, d_addr, ctl_addr;
    logic        i_start, i_stall, i_stop, i_ready, i_abort;
    logic        d_start, d_stall, d_stop, d_ready;
    logic [15:0] data_out, ctl_data;
    logic        ctl_start, ctl_stall, ctl_stop, ctl_ready, ctl_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qspi_read_arbiter #(
        .ADDR_BITS        (24),
        .DATA_WIDTH_BYTES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_start   (i_start),
        .i_stall   (i_stall),
        .i_stop    (i_stop),
        .i_ready   (i_ready),
        .i_abort   (i_abort),
        .d_addr    (d_addr),
        .d_start   (d_start),
        .d_stall   (d_stall),
        .d_stop    (d_stop),
        .d_ready   (d_ready),
        .data_out  (data_out),
        .ctl_addr  (ctl_addr),
        .ctl_start (ctl_start),
        .ctl_stall (ctl_stall),
        .ctl_stop  (ctl_stop),
        .ctl_data  (ctl_data),
        .ctl_ready (ctl_ready),
        .ctl_busy  (ctl_busy)
    );

    typedef struct {
        logic        is;
        logic [23:0] ia;
        logic        ds;
        logic [23:0] da;
        logic        ist, isp, dst, dsp, rdy, busy;
        logic [5:0]  eb;     // {ctl_start, ctl_stop, ctl_stall, i_ready, d_ready, i_abort}
        logic [23:0] ea;     // expected ctl_addr
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic is, input logic [23:0] ia,
                                input logic ds, input logic [23:0] da,
                                input logic ist, input logic isp,
                                input logic dst, input logic dsp,
                                input logic rdy, input logic busy,
                                input logic [5:0] eb, input logic [23:0] ea);
        vec_t v;
        v.is = is; v.ia = ia; v.ds = ds; v.da = da;
        v.ist = ist; v.isp = isp; v.dst = dst; v.dsp = dsp;
        v.rdy = rdy; v.busy = busy; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    function automatic logic [29:0] outs();
        return {ctl_start, ctl_stop, ctl_stall, i_ready, d_ready, i_abort, ctl_addr};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        i_start = 0; i_stall = 0; i_stop = 0;
        d_start = 0; d_stall = 0; d_stop = 0;
        ctl_ready = 0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // I stream 0x100, 4 beats, stop; then simultaneous I/D request.
        vecs[0]  = mk(1,'h100,0,0,   0,0,0,0, 0,0, 6'b000000, 'h0);
        vecs[1]  = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h0);
        vecs[2]  = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b100000, 'h100);
        vecs[3]  = mk(0,0,    0,0,   0,0,0,0, 1,1, 6'b000100, 'h100);
        vecs[4]  = mk(0,0,    0,0,   0,0,0,0, 1,1, 6'b000100, 'h102);
        vecs[5]  = mk(0,0,    0,0,   0,0,0,0, 1,1, 6'b000100, 'h104);
        vecs[6]  = mk(0,0,    0,0,   0,0,0,0, 1,1, 6'b000100, 'h106);
        vecs[7]  = mk(0,0,    0,0,   0,1,0,0, 0,1, 6'b000000, 'h108);
        vecs[8]  = mk(0,0,    0,0,   0,0,0,0, 0,1, 6'b010000, 'h108);
        vecs[9]  = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h108);
        vecs[10] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h108);
        vecs[11] = mk(1,'h10, 1,'h20,0,0,0,0, 0,0, 6'b000000, 'h108);
        vecs[12] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h108);
        vecs[13] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b100000, 'h20);
        vecs[14] = mk(0,0,    0,0,   0,0,0,0, 1,1, 6'b000010, 'h20);
        vecs[15] = mk(0,0,    0,0,   0,0,1,0, 1,1, 6'b001010, 'h22);
        vecs[16] = mk(0,0,    0,0,   0,0,0,1, 0,1, 6'b000000, 'h22);
        vecs[17] = mk(0,0,    0,0,   0,0,0,0, 0,1, 6'b010000, 'h22);
        vecs[18] = mk(0,0,    0,0,   0,0,0,0, 0,1, 6'b000000, 'h22);
        vecs[19] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h22);
        vecs[20] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b100000, 'h10);
        vecs[21] = mk(0,0,    0,0,   0,1,0,0, 0,1, 6'b000000, 'h10);
        vecs[22] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b010000, 'h10);
        vecs[23] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h10);
        vecs[24] = mk(0,0,    0,0,   0,0,0,0, 0,0, 6'b000000, 'h10);

        rst = 1'b1;
        i_addr = '0; d_addr = '0; ctl_data = '0; ctl_busy = 1'b0;
        clr();
        mid();
        chk("reset_state", {2'b0, outs()}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int k = 0; k < NV; k++) begin
            cyc();
            i_start = vecs[k].is;  i_addr = vecs[k].ia;
            d_start = vecs[k].ds;  d_addr = vecs[k].da;
            i_stall = vecs[k].ist; i_stop = vecs[k].isp;
            d_stall = vecs[k].dst; d_stop = vecs[k].dsp;
            ctl_ready = vecs[k].rdy; ctl_busy = vecs[k].busy;
            ctl_data = 16'hA000 + 16'(k);
            mid();
            chk($sformatf("vec%0d", k), {2'b0, outs()}, {2'b0, vecs[k].eb, vecs[k].ea});
            if (k == 3) chk("data_out_pass", {16'h0, data_out}, 32'h0000A003);
        end

        // ---------------- pre-emption of I by D ----------------
        cyc(); i_start = 1; i_addr = 24'h000100; mid();
        cyc(); mid();
        cyc(); mid();
        chk("pre_launch_i", {31'h0, ctl_start}, 32'h1);
        chk("pre_launch_addr", {8'h0, ctl_addr}, 32'h000100);
        for (int b = 0; b < 3; b++) begin
            cyc(); ctl_ready = 1; ctl_busy = 1; mid();
            chk($sformatf("pre_beat%0d", b), {31'h0, i_ready}, 32'h1);
        end
        cyc(); d_start = 1; d_addr = 24'h008000; mid();
        cyc(); mid();
        chk("pre_stop", {31'h0, ctl_stop}, 32'h1);
        chk("pre_abort", {31'h0, i_abort}, {31'h0, ~RESUME});
        cyc(); mid();
        chk("pre_abort_pulse", {30'h0, i_abort, ctl_stop}, 32'h0);
        cyc(); ctl_busy = 0; mid();
        chk("pre_wait_busy", {31'h0, ctl_start}, 32'h0);
        cyc(); mid();
        chk("pre_launch_d", {31'h0, ctl_start}, 32'h1);
        chk("pre_launch_d_addr", {8'h0, ctl_addr}, 32'h008000);
        chk("pre_i_next", {8'h0, dut.u_track_i.next_addr}, 32'h000106);
        cyc(); ctl_ready = 1; ctl_busy = 1; mid();
        chk("pre_d_beat", {30'h0, d_ready, i_ready}, 32'h2);
        cyc(); d_stop = 1; mid();
        cyc(); ctl_busy = 0; mid();
        chk("pre_d_stop", {31'h0, ctl_stop}, 32'h1);
        cyc(); mid();
        cyc(); mid();
        chk("post_d_relaunch", {31'h0, ctl_start}, {31'h0, RESUME});
        chk("post_d_addr", {8'h0, ctl_addr}, RESUME ? 32'h000106 : 32'h008002);
        cyc(); i_stop = 1; mid();
        cyc(); mid();
        cyc(); mid();
        cyc(); mid();
        chk("pre_idle", {30'h0, ctl_start, ctl_stop}, 32'h0);

        // ---------------- owner stall ----------------
        cyc(); i_start = 1; i_addr = 24'h000200; mid();
        cyc(); mid();
        cyc(); mid();
        chk("stall_launch", {31'h0, ctl_start}, 32'h1);
        for (int s = 0; s < 5; s++) begin
            cyc(); ctl_ready = 1; i_stall = 1; ctl_busy = 1; mid();
            chk($sformatf("stall_hold%0d", s), {31'h0, ctl_stall}, 32'h1);
        end
        cyc(); mid();
        chk("stall_addr_held", {8'h0, dut.u_track_i.next_addr}, 32'h000200);
        cyc(); ctl_ready = 1; mid();
        chk("stall_release", {30'h0, ctl_stall, i_ready}, 32'h1);
        cyc(); mid();
        chk("stall_one_inc", {8'h0, dut.u_track_i.next_addr}, 32'h000202);
        cyc(); i_stop = 1; mid();
        cyc(); ctl_busy = 0; mid();
        cyc(); mid();
        cyc(); mid();

        // ---------------- address wrap ----------------
        cyc(); i_start = 1; i_addr = 24'hFFFFFE; mid();
        cyc(); mid();
        cyc(); mid();
        chk("wrap_launch_addr", {8'h0, ctl_addr}, 32'hFFFFFE);
        cyc(); ctl_ready = 1; ctl_busy = 1; mid();
        cyc(); ctl_ready = 1; mid();
        cyc(); mid();
        chk("wrap_next", {8'h0, dut.u_track_i.next_addr}, 32'h000002);
        cyc(); i_stop = 1; mid();
        cyc(); ctl_busy = 0; mid();
        cyc(); mid();
        cyc(); mid();

        // ---------------- async reset during RUN_D ----------------
        cyc(); d_start = 1; d_addr = 24'h000400; mid();
        cyc(); mid();
        cyc(); mid();
        chk("rst_launch_d", {31'h0, ctl_start}, 32'h1);
        cyc(); ctl_ready = 1; d_stall = 1; ctl_busy = 1; mid();
        chk("rst_pre_run", {30'h0, d_ready, ctl_stall}, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outs", {2'b0, outs()}, 32'h0);
        clr();
        @(posedge clk);
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
